// File: rtl/clk_div_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel divider.
package clk_div_pkg;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Divisor that yields out_hz from board_hz; square mode toggles twice per period.
  function automatic int unsigned div_for_hz(input int unsigned board_hz,
                                             input int unsigned out_hz,
                                             input logic        mode);
    if (out_hz == 0) return 0;
    return (mode == MODE_PULSE) ? board_hz / out_hz : board_hz / (32'd2 * out_hz);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending config shadow, event and output logic.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W        = 24,
  parameter int unsigned DEFAULT_DIV  = 100000,
  parameter bit          DEFAULT_MODE = 1'b0
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             mode_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_div_q, act_div_d, pnd_div_q, pnd_div_d;
  logic             act_mode_q, act_mode_d, pnd_mode_q, pnd_mode_d;
  logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
  logic             idle, evt, apply, mode_chg;

  // A stopped or disabled channel is idle; the period event fires on the last count.
  always_comb begin
    idle     = !en_i || (act_div_q == '0);
    evt      = !idle && (cnt_q == act_div_q - CNT_W'(1));
    apply    = clr_i || idle || evt;
    mode_chg = apply && (pnd_mode_q != act_mode_q);
  end

  // Next-state: shadow config transfer, then counter/output update by precedence.
  always_comb begin
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    act_mode_d = act_mode_q;
    pnd_div_d  = pnd_div_q;
    pnd_mode_d = pnd_mode_q;
    pend_d     = pend_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;

    // Apply uses the pending value from before this edge; a same-edge write stays pending.
    if (apply) begin
      act_div_d  = pnd_div_q;
      act_mode_d = pnd_mode_q;
      pend_d     = 1'b0;
    end
    if (we_i) begin
      pnd_div_d  = div_i;
      pnd_mode_d = mode_i;
      pend_d     = 1'b1;
    end

    if (clr_i || idle) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (evt) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (mode_chg)                     clk_d = 1'b0;
      else if (act_mode_q == MODE_PULSE) clk_d = 1'b1;
      else                              clk_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (act_mode_q == MODE_PULSE) clk_d = 1'b0;
    end
  end

  // State registers; reset drops outputs immediately and restores defaults.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      act_div_q  <= CNT_W'(DEFAULT_DIV);
      pnd_div_q  <= CNT_W'(DEFAULT_DIV);
      act_mode_q <= DEFAULT_MODE;
      pnd_mode_q <= DEFAULT_MODE;
      pend_q     <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      pnd_div_q  <= pnd_div_d;
      act_mode_q <= act_mode_d;
      pnd_mode_q <= pnd_mode_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick divider: config decode plus NUM_CH channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 24,
  parameter int unsigned DEFAULT_DIV  = div_for_hz(100_000_000, 500, MODE_SQUARE),
  parameter bit          DEFAULT_MODE = MODE_SQUARE
) (
  input  logic                                        clk_in,
  input  logic                                        reset_n,
  input  logic [NUM_CH-1:0]                           enable,
  input  logic                                        cfg_we,
  input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]                            cfg_div,
  input  logic                                        cfg_mode,
  input  logic                                        sync_clr,
  output logic [NUM_CH-1:0]                           clk_out,
  output logic [NUM_CH-1:0]                           tick,
  output logic [NUM_CH-1:0]                           cfg_pending
);

  logic              cfg_ok;
  logic [NUM_CH-1:0] ch_we;

  // Writes to a channel index beyond NUM_CH are dropped.
  assign cfg_ok = cfg_we && (int'(cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = cfg_ok && (int'(cfg_ch) == i);

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_MODE(DEFAULT_MODE)
    ) u_chan (
      .clk_in (clk_in),
      .reset_n(reset_n),
      .en_i   (enable[i]),
      .clr_i  (sync_clr),
      .we_i   (ch_we[i]),
      .div_i  (cfg_div),
      .mode_i (cfg_mode),
      .clk_o  (clk_out[i]),
      .tick_o (tick[i]),
      .pend_o (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench: stimulus pushes hand-computed per-edge expectations,
// a negedge monitor pops and compares against {clk_out, tick, cfg_pending}.
module tb_clk_div_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  logic              clk_in = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] enable;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic              sync_clr;
  logic [NUM_CH-1:0] clk_out, tick, cfg_pending;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4),
    .DEFAULT_MODE(1'b0)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_mode   (cfg_mode),
    .sync_clr   (sync_clr),
    .clk_out    (clk_out),
    .tick       (tick),
    .cfg_pending(cfg_pending)
  );

  always #5 clk_in = ~clk_in;

  logic [8:0] exp_q[$];
  string      nm_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic push(input string nm, input logic [2:0] co, input logic [2:0] tk,
                      input logic [2:0] pd);
    exp_q.push_back({co, tk, pd});
    nm_q.push_back(nm);
  endtask

  // Expectation for the state right after the next rising edge.
  task automatic chk(input string nm, input logic [2:0] co, input logic [2:0] tk,
                     input logic [2:0] pd);
    @(posedge clk_in);
    #1 push(nm, co, tk, pd);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [CNT_W-1:0] dv, input logic md);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_mode = md;
  endtask

  logic [8:0] mon_e;
  string      mon_n;
  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = nm_q.pop_front();
      n_chk++;
      if ({clk_out, tick, cfg_pending} !== mon_e) begin
        n_fail++;
        $display("FAIL %s: got clk_out=%b tick=%b pend=%b, want clk_out=%b tick=%b pend=%b",
                 mon_n, clk_out, tick, cfg_pending, mon_e[8:6], mon_e[5:3], mon_e[2:0]);
      end
    end
  end

  initial begin
    int k1;
    logic c0, t0, c1, t1;
    reset_n = 1'b0; enable = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_mode = 1'b0; sync_clr = 1'b0;

    chk("reset", 3'b000, 3'b000, 3'b000);
    reset_n = 1'b1;
    enable  = 3'b001;

    // Default div 4 square on ch0: ticks on edges 4, 8, 12.
    for (int k = 1; k <= 12; k++)
      chk("t1_default", {2'b00, (k / 4) % 2 == 1}, {2'b00, k % 4 == 0}, 3'b000);

    // Shadowed divisor change lands at the end of the running period.
    chk("t2_run", 3'b001, 3'b000, 3'b000);
    cfg(2'd0, 8'd2, 1'b0);
    chk("t2_wr", 3'b001, 3'b000, 3'b001);
    cfg_we = 1'b0;
    chk("t2_pend", 3'b001, 3'b000, 3'b001);
    chk("t2_apply", 3'b000, 3'b001, 3'b000);
    chk("t2_div2", 3'b000, 3'b000, 3'b000);
    chk("t2_div2", 3'b001, 3'b001, 3'b000);
    chk("t2_div2", 3'b001, 3'b000, 3'b000);
    chk("t2_div2", 3'b000, 3'b001, 3'b000);

    // Pulse mode div 3 on ch1, configured while idle.
    enable = 3'b000;
    cfg(2'd1, 8'd3, 1'b1);
    chk("t3_wr", 3'b000, 3'b000, 3'b010);
    cfg_we = 1'b0;
    chk("t3_idle_apply", 3'b000, 3'b000, 3'b000);
    enable = 3'b010;
    for (int k = 1; k <= 9; k++)
      chk("t3_pulse", {1'b0, k % 3 == 0, 1'b0}, {1'b0, k % 3 == 0, 1'b0}, 3'b000);

    // div 0 stops ch1; mode change at the apply event forces clk_out low.
    cfg(2'd1, 8'd0, 1'b0);
    chk("t4_wr0", 3'b000, 3'b000, 3'b010);
    cfg_we = 1'b0;
    chk("t4_pend0", 3'b000, 3'b000, 3'b010);
    chk("t4_apply0", 3'b000, 3'b010, 3'b000);
    for (int k = 0; k < 5; k++) chk("t4_div0", 3'b000, 3'b000, 3'b000);

    // div 1 square on ch2: clk_in/2 with tick stuck high.
    cfg(2'd2, 8'd1, 1'b0);
    chk("t4_wr1", 3'b000, 3'b000, 3'b100);
    cfg_we = 1'b0;
    chk("t4_apply1", 3'b000, 3'b000, 3'b000);
    enable = 3'b110;
    for (int k = 1; k <= 4; k++)
      chk("t4_div1", {k % 2 == 1, 2'b00}, 3'b100, 3'b000);

    // Out-of-range channel index is ignored.
    cfg(2'd3, 8'd7, 1'b1);
    chk("t4_oor", 3'b100, 3'b100, 3'b000);
    cfg_we = 1'b0;
    chk("t4_oor", 3'b000, 3'b100, 3'b000);

    // ch0 div 3, ch1 div 5, started out of phase, then sync_clr.
    enable = 3'b000;
    cfg(2'd0, 8'd3, 1'b0);
    chk("t5_wr0", 3'b000, 3'b000, 3'b001);
    cfg(2'd1, 8'd5, 1'b0);
    chk("t5_wr1", 3'b000, 3'b000, 3'b010);
    cfg_we = 1'b0;
    chk("t5_idle", 3'b000, 3'b000, 3'b000);
    enable = 3'b001;
    for (int k0 = 1; k0 <= 9; k0++) begin
      if (k0 == 3) enable = 3'b011;
      k1 = (k0 >= 3) ? k0 - 2 : 0;
      c0 = ((k0 / 3) % 2) == 1; t0 = (k0 % 3) == 0;
      c1 = ((k1 / 5) % 2) == 1; t1 = (k1 != 0) && (k1 % 5 == 0);
      chk("t5_skew", {1'b0, c1, c0}, {1'b0, t1, t0}, 3'b000);
    end
    sync_clr = 1'b1;
    chk("t5_clr", 3'b000, 3'b000, 3'b000);
    sync_clr = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      c0 = ((k / 3) % 2) == 1; t0 = (k % 3) == 0;
      c1 = ((k / 5) % 2) == 1; t1 = (k % 5) == 0;
      chk("t5_align", {1'b0, c1, c0}, {1'b0, t1, t0}, 3'b000);
    end

    // Async reset mid-period with a pending write outstanding.
    cfg(2'd0, 8'd9, 1'b1);
    @(posedge clk_in);
    cfg_we = 1'b0;
    #2 reset_n = 1'b0;
    #1 push("t6_async", 3'b000, 3'b000, 3'b000);
    chk("t6_hold", 3'b000, 3'b000, 3'b000);
    reset_n = 1'b1;
    enable  = 3'b001;
    for (int k = 1; k <= 8; k++)
      chk("t6_default", {2'b00, (k / 4) % 2 == 1}, {2'b00, k % 4 == 0}, 3'b000);

    repeat (2) @(negedge clk_in);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
